// File: rtl/minmax_pkg.sv
// Shared types and defaults for the min/max frame loader and its
// result register.
package minmax_pkg;

    localparam int DW_DEF     = 16;
    localparam int N_REGS_DEF = 8;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam int RES_VAL_W = DW_DEF;
    localparam int RES_ERR_W = 1;

    typedef struct packed {
        logic [RES_ERR_W-1:0] err;
        logic [RES_VAL_W-1:0] max;
        logic [RES_VAL_W-1:0] min;
        logic [RES_VAL_W-1:0] range;
    } result_t;

endpackage

// File: rtl/minmax_result_reg.sv
// Latches the finder result (or a timeout error) and holds it on a
// valid/ready port until downstream takes it.
module minmax_result_reg
    import minmax_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cap,
    input  logic          i_tmo,
    input  logic [DW-1:0] i_max,
    input  logic [DW-1:0] i_min,
    input  logic          i_ready,
    output logic          o_valid,
    output logic          o_done,
    output logic [DW-1:0] o_max,
    output logic [DW-1:0] o_min,
    output logic [DW-1:0] o_range,
    output logic          o_err
);

    logic          r_valid;
    logic [DW-1:0] r_max;
    logic [DW-1:0] r_min;
    logic [DW-1:0] r_range;
    logic          r_err;
    logic [DW-1:0] w_range;

    // unsigned, wraps modulo 2^DW when max < min
    assign w_range = i_max - i_min;
    assign o_done  = r_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_max   <= '0;
            r_min   <= '0;
            r_range <= '0;
            r_err   <= 1'b0;
        end else if (i_cap) begin
            r_valid <= 1'b1;
            r_max   <= i_max;
            r_min   <= i_min;
            r_range <= w_range;
            r_err   <= (i_max < i_min);
        end else if (i_tmo) begin
            r_valid <= 1'b1;
            r_max   <= '0;
            r_min   <= '0;
            r_range <= '0;
            r_err   <= 1'b1;
        end else if (o_done) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_max   = r_max;
    assign o_min   = r_min;
    assign o_range = r_range;
    assign o_err   = r_err;

endmodule

// File: rtl/minmax_frame_loader.sv
// Packs runs of N_REGS samples into finder register writes, then
// collects max/min/range per frame and hands it downstream.
module minmax_frame_loader
    import minmax_pkg::*;
#(
    parameter int DW            = DW_DEF,
    parameter int N_REGS        = N_REGS_DEF,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_data,
    output logic                      wr_en,
    output logic [$clog2(N_REGS)-1:0] wr_reg,
    output logic [DW-1:0]             wr_data,
    input  logic [DW-1:0]             fnd_max,
    input  logic [DW-1:0]             fnd_min,
    input  logic                      fnd_valid,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_max,
    output logic [DW-1:0]             out_min,
    output logic [DW-1:0]             out_range,
    output logic                      out_err,
    output logic [7:0]                frame_cnt
);

    localparam int IW   = $clog2(N_REGS);
    localparam int CMAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_REGS - 1);
    localparam logic [CW-1:0] SET_END  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] TMO_END  = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready;
    logic          r_wr_en;
    logic [IW-1:0] r_wr_reg;
    logic [DW-1:0] r_wr_data;
    logic [7:0]    r_frame;

    logic w_acc;
    logic w_cap;
    logic w_tmo;
    logic w_done;

    // r_in_ready is only ever set while heading into LOAD
    assign w_acc = in_valid & r_in_ready;
    assign w_cap = (r_state == S_WAIT) & fnd_valid;
    assign w_tmo = (r_state == S_WAIT) & ~fnd_valid & (r_cnt == TMO_END);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_LOAD: begin
                if (w_acc && (r_idx == LAST_IDX))
                    w_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == SET_END)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_cap || w_tmo)
                    w_next = S_HOLD;
            end
            S_HOLD: begin
                if (w_done)
                    w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOAD;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_frame    <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_LOAD);
            if (w_acc)
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            // SETTLE spans the final write cycle plus SETTLE_CYCLES idle ones
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_SETTLE || r_state == S_WAIT)
                r_cnt <= r_cnt + 1'b1;
            if (w_done)
                r_frame <= r_frame + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_acc;
            if (w_acc) begin
                r_wr_reg  <= r_idx;
                r_wr_data <= in_data;
            end
        end
    end

    minmax_result_reg #(
        .DW (DW)
    ) u_res (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_cap   (w_cap),
        .i_tmo   (w_tmo),
        .i_max   (fnd_max),
        .i_min   (fnd_min),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_done  (w_done),
        .o_max   (out_max),
        .o_min   (out_min),
        .o_range (out_range),
        .o_err   (out_err)
    );

    assign in_ready  = r_in_ready;
    assign wr_en     = r_wr_en;
    assign wr_reg    = r_wr_reg;
    assign wr_data   = r_wr_data;
    assign frame_cnt = r_frame;

endmodule
